// File: rtl/mips_cpu_hilo_unit.sv
// rtl/mips_cpu_hilo_unit.sv - HI/LO owner and iterative MULT/MULTU/DIV/DIVU sequencer (option: MIPS_HILO_FAST_MULT_EN)
module mips_cpu_hilo_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_use,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic               div_q;
    logic               res_neg, rem_neg, dz_q;
    logic [CW-1:0]      cnt;
    // r_hi: partial product high half / running remainder; r_lo: multiplier / dividend-quotient
    logic [WIDTH-1:0]   r_hi, r_lo, r_b;

    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH:0]     trial, sum;
    logic               qbit;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    assign a_neg  = ~op[0] & a[WIDTH-1];
    assign b_neg  = ~op[0] & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign b_zero = (b == '0);

    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (hilo_use | start);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op[1] && b_zero)
                        state_d = S_FIX;
`ifdef MIPS_HILO_FAST_MULT_EN
                    else if (!op[1])
                        state_d = S_FIX;
`endif
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN:   if (cnt == CW'(STEPS - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One RUN cycle: BITS_PER_CYCLE shift-add or restoring-divide steps chained combinationally
    always_comb begin
        step_hi = r_hi;
        step_lo = r_lo;
        trial   = '0;
        sum     = '0;
        qbit    = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (div_q) begin
                trial = {step_hi, step_lo[WIDTH-1]};
                if (trial >= {1'b0, r_b}) begin
                    trial = trial - {1'b0, r_b};
                    qbit  = 1'b1;
                end else begin
                    qbit  = 1'b0;
                end
                step_hi = trial[WIDTH-1:0];
                step_lo = {step_lo[WIDTH-2:0], qbit};
            end else begin
                sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
                step_lo = {sum[0], step_lo[WIDTH-1:1]};
                step_hi = sum[WIDTH:1];
            end
        end
    end

    always_comb begin
`ifdef MIPS_HILO_FAST_MULT_EN
        prod_mag = {{WIDTH{1'b0}}, r_lo} * {{WIDTH{1'b0}}, r_b};
`else
        prod_mag = {r_hi, r_lo};
`endif
        prod   = res_neg ? -prod_mag : prod_mag;
        quo    = res_neg ? -r_lo : r_lo;
        rem    = rem_neg ? -r_hi : r_hi;
        fix_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        fix_lo = div_q ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            div_q    <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            dz_q     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else begin
            state_q  <= state_d;
            done     <= (state_q == S_FIX);
            div_zero <= (state_q == S_FIX) && dz_q;
            case (state_q)
                S_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        div_q   <= op[1];
                        r_hi    <= '0;
                        r_lo    <= a_mag;
                        r_b     <= b_mag;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        dz_q    <= op[1] & b_zero;
                        cnt     <= '0;
                    end
                end
                S_RUN: begin
                    r_hi <= step_hi;
                    r_lo <= step_lo;
                    cnt  <= cnt + CW'(1);
                end
                S_FIX: begin
                    if (!dz_q) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// tb/tb_mips_cpu_hilo_unit.sv - self-checking bench for mips_cpu_hilo_unit
module tb_mips_cpu_hilo_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0, hilo_use = 1'b0;
    logic        busy, done, div_zero, stall;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[$];

    mips_cpu_hilo_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hilo_use(hilo_use),
        .busy(busy), .done(done), .div_zero(div_zero), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural operands
    task automatic model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p;
        sx = o[0] ? longint'({32'h0, x}) : longint'($signed(x));
        sy = o[0] ? longint'({32'h0, y}) : longint'($signed(y));
        m_dz = 1'b0;
        if (!o[1]) begin
            p = sx * sy;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (y == 0) begin
            m_dz = 1'b1;
        end else begin
            p = sx / sy;
            m_lo = p[31:0];
            p = sx % sy;
            m_hi = p[31:0];
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
        if (o[1] && y == 0) return 2;
`ifdef MIPS_HILO_FAST_MULT_EN
        if (!o[1]) return 2;
`endif
        return 34;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic with_mt, input logic poke,
                         output logic [31:0] gh, output logic [31:0] gl, output logic gdz);
        int lat, n, nbusy;
        logic seen;
        logic [31:0] lo_before;
        lat = exp_lat(o, y);
        lo_before = '0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (with_mt) begin mthi = 1'b1; wdata = 32'hA5A5_0001; end
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; a = $urandom; b = $urandom;
        n = 1; seen = 1'b0; nbusy = 0;
        while (n <= 100 && !seen) begin
            if (n == 1 && with_mt) check("mthi_same_cycle", hi, 32'hA5A5_0001);
            if (n == 2 && poke && lat > 3) begin
                lo_before = lo;
                mtlo = 1'b1; wdata = ~lo; hilo_use = 1'b1;
                #1 check("stall_hilo_use", stall, 1);
            end
            if (n == 3 && poke && lat > 3) begin
                check("mtlo_ignored_busy", lo, lo_before);
                mtlo = 1'b0; hilo_use = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                check("busy_low_at_done", busy, 0);
            end else begin
                if (busy) nbusy++;
                @(negedge clk);
                n++;
            end
        end
        check("latency", n, lat);
        check("busy_cycles", nbusy, lat - 1);
        gh = hi; gl = lo; gdz = div_zero;
        @(negedge clk);
        check("done_one_cycle", {done, div_zero}, 0);
    endtask

    initial begin
        logic [31:0] gh, gl;
        logic gdz;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        int ndone;

        vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{2'b11, 32'd100,      32'd7,        32'd2,        32'd14});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000});
        vecs.push_back('{2'b01, 32'd3,        32'd5,        32'h0,        32'd15});
        vecs.push_back('{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
        vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0});
        vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF});
        vecs.push_back('{2'b11, 32'd5,        32'd9,        32'd5,        32'd0});
        vecs.push_back('{2'b00, 32'd0,        32'hFFFFFFFF, 32'h0,        32'h0});
        vecs.push_back('{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2});

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        hilo_use = 1'b1;
        #1;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_flags", {busy, done, div_zero}, 0);
        check("stall_idle", stall, 0);
        hilo_use = 1'b0;
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, gh, gl, gdz);
            model_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_hi", i), gh, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), gl, vecs[i].lo);
            check($sformatf("vec%0d_dz", i), gdz, 0);
        end

        // MTHI / MTLO then divide by zero leaves HI/LO untouched
        @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
        @(negedge clk); mtlo = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);
        m_hi = 32'h1234; m_lo = 32'h5678;
        do_op(2'b10, 32'd77, 32'd0, 1'b0, 1'b0, gh, gl, gdz);
        check("dz_flag", gdz, 1);
        check("dz_hi", gh, 32'h1234);
        check("dz_lo", gl, 32'h5678);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'hCAFE, 32'hCAFE});

        // start together with MTHI in IDLE; result overwrites afterwards
        do_op(2'b01, 32'd3, 32'd5, 1'b1, 1'b0, gh, gl, gdz);
        check("start_mthi_result", {gh, gl}, {32'h0, 32'd15});

        // second start ignored while busy, then reset mid-op aborts
        @(negedge clk); start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 5) begin
                start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
                #1 check("stall_second_start", stall, 1);
            end
            if (n == 6) start = 1'b0;
            if (n == 10) reset_n = 1'b0;
            if (n < 10) @(negedge clk);
        end
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_hilo", {hi, lo}, 0);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            if ($urandom_range(0, 7) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else                                rb = 32'($urandom_range(1, 20));
            do_op(ro, ra, rb, 1'b0, 1'b1, gh, gl, gdz);
            model_op(ro, ra, rb);
            check($sformatf("rnd%0d_hi", i), gh, m_hi);
            check($sformatf("rnd%0d_lo", i), gl, m_lo);
            check($sformatf("rnd%0d_dz", i), gdz, m_dz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
